// File: rtl/ysyx_23060180_lsu.sv
// Memory-stage load/store unit: one aligned word access per request over a gnt/rvalid
// data-memory handshake, returning extended load data or a store completion pulse.
module ysyx_23060180_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic              err_valid,
  output logic              err_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_load;
  logic [2:0]          r_func3;
  logic [1:0]          r_off;
  logic [4:0]          r_rd;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err_valid;
  logic                r_err_cause;

  logic                w_accept;
  logic                w_illegal;
  logic                w_misaligned;
  logic                w_go;
  logic [3:0]          w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_load_ext;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Loads reject 011/11x, stores reject 1xx/011; exactly one of load/store must be set.
  assign w_illegal = (req_load == req_store)
                   | (req_load  & ((req_func3 == 3'b011) | (req_func3[2:1] == 2'b11)))
                   | (req_store & (req_func3[2] | (req_func3[1:0] == 2'b11)));

  assign w_misaligned = ((req_func3[1:0] == 2'b01) & req_addr[0])
                      | ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

  assign w_go = w_accept & ~w_illegal & ~w_misaligned;

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = req_wdata;
    if (req_store) begin
      case (req_func3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << {req_addr[1], 1'b0};
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: w_wstrb = 4'b1111;
      endcase
    end
  end

  // Halfword offsets are always even here, so one byte-granular shift serves both widths.
  assign w_shifted = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_func3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_state_next = S_REQ;
      S_REQ:  if (dmem_gnt) w_state_next = r_load ? S_WAIT : S_RESP;
      S_WAIT: if (dmem_rvalid) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_func3     <= 3'd0;
      r_off       <= 2'd0;
      r_rd        <= 5'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= 4'd0;
      r_rdata     <= '0;
      r_err_valid <= 1'b0;
      r_err_cause <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_err_valid <= w_accept & (w_illegal | w_misaligned);
      r_err_cause <= w_accept & w_illegal;
      if (w_go) begin
        r_load  <= req_load;
        r_func3 <= req_func3;
        r_off   <= req_addr[1:0];
        r_rd    <= req_rd;
        r_we    <= req_store;
        r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
      end
      if ((r_state == S_WAIT) && dmem_rvalid) begin
        r_rdata <= w_load_ext;
      end
    end
  end

  // Request and response strobes come straight from the state register so an
  // asynchronous reset withdraws them immediately.
  assign dmem_req   = (r_state == S_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_wstrb;

  assign resp_valid = (r_state == S_RESP);
  assign resp_we    = resp_valid & r_load;
  assign resp_rd    = resp_we ? r_rd : 5'd0;
  assign resp_data  = resp_we ? r_rdata : '0;

  assign err_valid  = r_err_valid;
  assign err_cause  = r_err_cause;

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Self-checking bench for ysyx_23060180_lsu: directed vector table, randomized ops
// against a behavioural model, and a reset-during-WAIT sequence.
module tb_ysyx_23060180_lsu;

  logic        clk = 1'b0;
  logic        rstn_in;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        resp_valid, resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        err_valid, err_cause;

  int errors = 0;
  int checks = 0;

  ysyx_23060180_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn_in(rstn_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .err_valid(err_valid), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    logic        e_err;
    logic        e_cause;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [4:0] rd, int gd, int rvd,
                              logic [31:0] rdata, logic e_err, logic e_cause,
                              logic [3:0] e_wstrb, logic [31:0] e_wdata, logic [31:0] e_data);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.gd = gd; v.rvd = rvd; v.rdata = rdata; v.e_err = e_err; v.e_cause = e_cause;
    v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_data = e_data;
    return v;
  endfunction

  // Reference model: derives expectations from access size and byte offset arithmetic.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int nbytes = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
    int off = int'(v.addr % 4);
    bit legal_ld = v.ld && !v.st && (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bit legal_st = v.st && !v.ld && (v.f3 inside {3'd0, 3'd1, 3'd2});
    longint val;
    longint span;
    r.e_err = 1'b0; r.e_cause = 1'b0; r.e_wstrb = 4'd0; r.e_wdata = 32'd0; r.e_data = 32'd0;
    if (!(legal_ld || legal_st)) begin
      r.e_err = 1'b1; r.e_cause = 1'b1;
    end else if ((v.addr % nbytes) != 0) begin
      r.e_err = 1'b1; r.e_cause = 1'b0;
    end else if (legal_st) begin
      span = (longint'(1) << (8 * nbytes)) - 1;
      val = longint'(v.wdata) & span;
      r.e_wstrb = 4'(((1 << nbytes) - 1) << off);
      r.e_wdata = (nbytes == 1) ? 32'(val * 32'h01010101) :
                  (nbytes == 2) ? 32'(val * 32'h00010001) : 32'(val);
    end else begin
      span = longint'(1) << (8 * nbytes);
      val = (longint'(v.rdata) >> (8 * off)) % span;
      if (!v.f3[2] && nbytes < 4 && val >= span / 2) val = val - span;
      r.e_data = 32'(val);
    end
    return r;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    logic [31:0] exp_addr;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    check({tag, " ready"}, req_ready, 1);
    req_valid = 1'b1; req_load = v.ld; req_store = v.st; req_func3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    step();
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    if (v.e_err) begin
      check({tag, " err_valid"}, err_valid, 1);
      check({tag, " err_cause"}, err_cause, v.e_cause);
      check({tag, " err no dmem_req"}, dmem_req, 0);
      check({tag, " err ready"}, req_ready, 1);
      check({tag, " err no resp"}, resp_valid, 0);
      step();
      check({tag, " err pulse"}, err_valid, 0);
      check({tag, " err no dmem_req later"}, dmem_req, 0);
      return;
    end
    check({tag, " no err"}, err_valid, 0);
    for (int i = 0; i < v.gd; i++) begin
      check({tag, " req held"}, dmem_req, 1);
      check({tag, " resp early"}, resp_valid, 0);
      step();
    end
    check({tag, " dmem_req"}, dmem_req, 1);
    check({tag, " dmem_we"}, dmem_we, v.st);
    check({tag, " dmem_addr"}, dmem_addr, exp_addr);
    check({tag, " dmem_wstrb"}, dmem_wstrb, v.e_wstrb);
    if (v.st) check({tag, " dmem_wdata"}, dmem_wdata, v.e_wdata);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check({tag, " req dropped"}, dmem_req, 0);
    if (v.ld) begin
      for (int i = 0; i < v.rvd; i++) begin
        check({tag, " resp early"}, resp_valid, 0);
        step();
      end
      check({tag, " resp early"}, resp_valid, 0);
      dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
      step();
      dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    end
    check({tag, " resp_valid"}, resp_valid, 1);
    check({tag, " resp_we"}, resp_we, v.ld);
    check({tag, " resp_rd"}, resp_rd, v.ld ? v.rd : 5'd0);
    check({tag, " resp_data"}, resp_data, v.e_data);
    check({tag, " resp no err"}, err_valid, 0);
    step();
    check({tag, " resp pulse"}, resp_valid, 0);
    check({tag, " ready after"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rstn_in = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

    tbl[0]  = mk(0, 1, 3'b010, 32'h80000104, 32'hDEADBEEF, 5'd3, 0, 0, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 1, 3'b000, 32'h80000003, 32'h000000A5, 5'd4, 0, 0, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    tbl[2]  = mk(1, 0, 3'b000, 32'h80000201, 0, 5'd5, 0, 0, 32'h80F07F12, 0, 0, 4'b0000, 0, 32'h0000007F);
    tbl[3]  = mk(1, 0, 3'b000, 32'h80000202, 0, 5'd6, 0, 0, 32'h80F07F12, 0, 0, 4'b0000, 0, 32'hFFFFFFF0);
    tbl[4]  = mk(1, 0, 3'b100, 32'h80000203, 0, 5'd7, 0, 0, 32'h80F07F12, 0, 0, 4'b0000, 0, 32'h00000080);
    tbl[5]  = mk(1, 0, 3'b001, 32'h80000302, 0, 5'd8, 0, 0, 32'h8001FFFE, 0, 0, 4'b0000, 0, 32'hFFFF8001);
    tbl[6]  = mk(1, 0, 3'b101, 32'h80000300, 0, 5'd9, 0, 0, 32'h8001FFFE, 0, 0, 4'b0000, 0, 32'h0000FFFE);
    tbl[7]  = mk(1, 0, 3'b010, 32'h80000300, 0, 5'd10, 3, 2, 32'h8001FFFE, 0, 0, 4'b0000, 0, 32'h8001FFFE);
    tbl[8]  = mk(1, 0, 3'b010, 32'h80000302, 0, 5'd11, 0, 0, 0, 1, 0, 4'b0000, 0, 0);
    tbl[9]  = mk(1, 0, 3'b011, 32'h80000300, 0, 5'd12, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
    tbl[10] = mk(1, 1, 3'b010, 32'h80000300, 0, 5'd13, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
    tbl[11] = mk(0, 1, 3'b001, 32'h80000402, 32'h1234ABCD, 5'd1, 1, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 0);
    tbl[12] = mk(0, 0, 3'b000, 32'h80000400, 0, 5'd2, 0, 0, 0, 1, 1, 4'b0000, 0, 0);

    step();
    check("reset dmem_req", dmem_req, 0);
    check("reset dmem_wstrb", dmem_wstrb, 0);
    check("reset dmem_addr", dmem_addr, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset err_valid", err_valid, 0);
    step();
    rstn_in = 1'b1;
    step();
    check("post-reset ready", req_ready, 1);

    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    check("stray rvalid idle", resp_valid, 0);

    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i));
      $display("vec %0d ld=%0b st=%0b f3=%0d addr=%h done", i, tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].addr);
    end

    for (int n = 0; n < 80; n++) begin
      int sel = $urandom_range(0, 19);
      v.ld = (sel < 10) || (sel == 18);
      v.st = ((sel >= 10) && (sel < 18)) || (sel == 18);
      v.f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
             (v.st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000));
      v.addr = 32'h80000000 | ($urandom & 32'h0000FFFF);
      v.wdata = $urandom;
      v.rd = 5'($urandom);
      v.gd = $urandom_range(0, 3);
      v.rvd = $urandom_range(0, 3);
      v.rdata = $urandom;
      v = model(v);
      do_op(v, $sformatf("rnd%0d", n));
      $display("rnd %0d ld=%0b st=%0b f3=%0d addr=%h err=%0b data=%h", n, v.ld, v.st, v.f3, v.addr, v.e_err, v.e_data);
    end

    req_valid = 1'b1; req_load = 1'b1; req_func3 = 3'b010; req_addr = 32'h80000010; req_rd = 5'd7;
    step();
    req_valid = 1'b0; req_load = 1'b0;
    check("rstwait dmem_req", dmem_req, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    step();
    rstn_in = 1'b0;
    #1;
    check("rstwait req drop", dmem_req, 0);
    check("rstwait no resp", resp_valid, 0);
    step();
    rstn_in = 1'b1;
    step();
    check("rstwait idle", req_ready, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_rvalid = 1'b0;
    check("rstwait late rvalid", resp_valid, 0);
    step();
    check("rstwait still quiet", resp_valid, 0);
    $display("reset-during-wait sequence done");

    v = mk(1, 0, 3'b010, 32'h80000020, 0, 5'd15, 1, 1, 32'hCAFEF00D, 0, 0, 4'b0000, 0, 32'hCAFEF00D);
    do_op(v, "fresh_lw");
    $display("fresh LW after reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
